regfile_write_arbiter: RTL

- Shares the single write port of the 32x32 RegisterFile between two requesters (A, B) using round-robin arbitration and a Req/Grant handshake.
- After reset, a clear sequencer first writes zero to every register; only then does arbitration start.
- Sits directly in front of RegisterFile and drives its WriteRegister, WriteData and RegWrite inputs.
- The read ports of RegisterFile are untouched.

---
 rtl/regfile_write_arbiter_pkg.sv | 37 +++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_pkg
//  Description : Shared types and constants for the register-file write
//                arbiter: FSM state encoding, register-file constants,
//                requester IDs and the 2-way round-robin pick function.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

  // Top-level sequencer states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Register 0 is hardwired to zero in the register file
  localparam int REG_ZERO = 0;
  localparam int NUM_REGS = 32;

  // Requester IDs, also the bit positions in request/grant vectors
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  // Round-robin pick between two requesters. ptr names the side that wins
  // a tie (0 = A, 1 = B). The result is one-hot or zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] pick;
    pick = req;
    if (req == 2'b11) begin
      pick = ptr ? 2'b10 : 2'b01;
    end
    return pick;
  endfunction

endpackage : regfile_write_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. Takes eligible request bits and
//                returns a one-hot grant in the same cycle. The priority
//                pointer moves to the other side after every grant, whether
//                or not there was contention.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  // Priority pointer: 0 = A wins a tie, 1 = B wins a tie
  logic ptr_q;
  logic ptr_d;

  assign grant_o = rr_pick(req_i, ptr_q);

  // Hand priority to the side that was not just served
  always_comb begin
    ptr_d = ptr_q;
    if (grant_o[REQ_A]) begin
      ptr_d = 1'(REQ_B);
    end else if (grant_o[REQ_B]) begin
      ptr_d = 1'(REQ_A);
    end
  end

  // Pointer register, starts favouring A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'(REQ_A);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single write port of a register file between two
//                requesters (A, B) with round-robin arbitration and a
//                Req/Grant handshake. After reset every register is cleared
//                to zero before arbitration starts. All outputs registered.
//  Options     : REGARB_STATS_EN - adds ConflictCount[15:0], a saturating
//                count of RUN cycles in which both requests were eligible.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  ReqA,
  input  logic [ADDR_WIDTH-1:0] RegA,
  input  logic [DATA_WIDTH-1:0] DataA,
  output logic                  GrantA,
  input  logic                  ReqB,
  input  logic [ADDR_WIDTH-1:0] RegB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  GrantB,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite,
`ifdef REGARB_STATS_EN
  output logic [15:0]           ConflictCount,
`endif
  output logic                  Busy
);

  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    grant_a_q;
  logic                    grant_b_q;
  logic                    regwrite_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   wreg_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [1:0]              elig;
  logic [1:0]              arb_grant;

  // A request is eligible only in RUN and only if it is not being granted
  // right now; this keeps a held request from being consumed twice.
  assign elig[REQ_A] = (state_q == ST_RUN) && ReqA && !grant_a_q;
  assign elig[REQ_B] = (state_q == ST_RUN) && ReqB && !grant_b_q;

  rr_arbiter2 u_rr (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .req_i   (elig),
    .grant_o (arb_grant)
  );

  // Clear sequencer followed by the arbitrated write mux
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      grant_a_q  <= 1'b0;
      grant_b_q  <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          grant_a_q  <= 1'b0;
          grant_b_q  <= 1'b0;
          regwrite_q <= 1'b1;
          wreg_q     <= idx_q;
          wdata_q    <= '0;
          idx_q      <= idx_q + ADDR_WIDTH'(1);
          if (idx_q == IDX_LAST) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          grant_a_q <= arb_grant[REQ_A];
          grant_b_q <= arb_grant[REQ_B];
          if (arb_grant[REQ_A]) begin
            wreg_q     <= RegA;
            wdata_q    <= DataA;
            regwrite_q <= (RegA != ADDR_WIDTH'(REG_ZERO));
          end else if (arb_grant[REQ_B]) begin
            wreg_q     <= RegB;
            wdata_q    <= DataB;
            regwrite_q <= (RegB != ADDR_WIDTH'(REG_ZERO));
          end else begin
            // Idle: address and data hold, only the strobe drops
            regwrite_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef REGARB_STATS_EN
  logic [15:0] conflict_q;

  // Saturating count of cycles with contention between A and B
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      conflict_q <= '0;
    end else if ((elig == 2'b11) && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign ConflictCount = conflict_q;
`endif

  assign GrantA        = grant_a_q;
  assign GrantB        = grant_b_q;
  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign Busy          = busy_q;

endmodule : regfile_write_arbiter
`default_nettype wire
